// File: rtl/scanner_pkg.sv
// Shared constants and state encoding for the read-address scanner.
package scanner_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; suppresses a rise on the first cycle after reset so a
// level held through reset release is not mistaken for a new press.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic hist;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      hist  <= in;
      armed <= 1'b1;
    end
  end

  assign rise = in & ~hist & armed;

endmodule

// File: rtl/addr_scanner.sv
// Read-address scanner: auto-advances every TICK_DIV cycles in RUN, steps on
// button edges in PAUSE. Define ADDR_SCANNER_SYNC_EN to synchronise run/step.
module addr_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              adv,
  output logic              wrap,
  output logic              running
);

  localparam int unsigned   PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic run_s;
  logic step_s;
  logic step_rise;

`ifdef ADDR_SCANNER_SYNC_EN
  logic [1:0] run_sync;
  logic [1:0] step_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_sync  <= 2'b00;
      step_sync <= 2'b00;
    end else begin
      run_sync  <= {run_sync[0], run};
      step_sync <= {step_sync[0], step};
    end
  end

  assign run_s  = run_sync[1];
  assign step_s = step_sync[1];
`else
  assign run_s  = run;
  assign step_s = step;
`endif

  edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .in    (step_s),
    .rise  (step_rise)
  );

  state_t            state, state_d;
  logic [PRE_W-1:0]  presc, presc_d;
  logic [ADDR_W-1:0] addr_d;
  logic              adv_d;
  logic              wrap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PAUSE;
      presc   <= '0;
      rd_addr <= '0;
      adv     <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_d;
      presc   <= presc_d;
      rd_addr <= addr_d;
      adv     <= adv_d;
      wrap    <= wrap_d;
      running <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state;
    presc_d = presc;
    addr_d  = rd_addr;
    adv_d   = 1'b0;
    wrap_d  = 1'b0;
    case (state)
      PAUSE: begin
        presc_d = '0;
        adv_d   = step_rise;
        if (run_s) state_d = RUN;
      end
      RUN: begin
        // Tick on the cycle after the prescaler reaches its terminal count.
        if (presc == PRE_MAX) begin
          presc_d = '0;
          adv_d   = 1'b1;
        end else begin
          presc_d = presc + PRE_W'(1);
        end
        if (!run_s) begin
          state_d = PAUSE;
          presc_d = '0;
        end
      end
    endcase
    if (adv_d) begin
      addr_d = rd_addr + ADDR_W'(1);
      wrap_d = (rd_addr == ADDR_W'(DEPTH - 1));
    end
  end

endmodule

// File: tb/tb_addr_scanner.sv
// Directed bench for addr_scanner with TICK_DIV = 4: vector table plus
// hand-written wrap, run/reset interaction and step-latency sequences.
module tb_addr_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic [4:0] rd_addr;
  logic       adv;
  logic       wrap;
  logic       running;

  int nvec = 0;
  int nerr = 0;

`ifdef ADDR_SCANNER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  addr_scanner #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .step    (step),
    .rd_addr (rd_addr),
    .adv     (adv),
    .wrap    (wrap),
    .running (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       reset;
    logic       run;
    logic       step;
    logic [4:0] addr;
    logic       adv;
    logic       wrap;
    logic       running;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rn, input logic st,
                              input int a, input logic ad, input logic w,
                              input logic ru);
    vec_t v;
    v.reset = r; v.run = rn; v.step = st;
    v.addr = 5'(a); v.adv = ad; v.wrap = w; v.running = ru;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int ea, input logic eadv,
                     input logic ewrap, input logic erun);
    nvec++;
    if (rd_addr !== 5'(ea) || adv !== eadv || wrap !== ewrap || running !== erun) begin
      nerr++;
      $display("FAIL %s @%0t: got addr=%0d adv=%b wrap=%b running=%b, want addr=%0d adv=%b wrap=%b running=%b",
               nm, $time, rd_addr, adv, wrap, running, ea, eadv, ewrap, erun);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;

`ifndef ADDR_SCANNER_SYNC_EN
    // Reset, auto-scan, reset, manual stepping.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++)
      vecs.push_back(mk(0, 1, 0, (k - 1) / 4, (k > 1) && (k % 4 == 1), 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    for (int p = 1; p <= 3; p++) begin
      vecs.push_back(mk(0, 0, 1, p, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, p, 0, 0, 0));
    end
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 0, 1, 4, i == 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].reset;
      run   = vecs[i].run;
      step  = vecs[i].step;
      cyc();
      chk($sformatf("vec%0d", i), int'(vecs[i].addr), vecs[i].adv,
          vecs[i].wrap, vecs[i].running);
    end

    // Step manually up to 30.
    for (int i = 0; i < 26; i++) begin
      step = 1'b1; cyc();
      step = 1'b0; cyc();
    end
    chk("step_to_30", 30, 0, 0, 0);

    // Auto-scan through 31 -> 0; wrap only on the second advance.
    run = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk($sformatf("wrap_e%0d", e), (e < 5) ? 30 : ((e < 9) ? 31 : 0),
          (e == 5) || (e == 9), e == 9, 1);
    end

    // Step presses in RUN are ignored; only the prescaler tick advances.
    for (int e = 10; e <= 15; e++) begin
      step = (e == 10) || (e == 14);
      cyc();
      chk($sformatf("run_step_e%0d", e), (e < 13) ? 0 : 1, e == 13, 0, 1);
    end

    // Reset at prescaler 2 with run and step high; step held through release.
    reset = 1'b1; step = 1'b1;
    cyc();
    chk("mid_run_reset", 0, 0, 0, 0);
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("held_step_release%0d", i), 0, 0, 0, 0);
    end
    step = 1'b0;
    cyc();
    chk("paused_after_reset", 0, 0, 0, 0);
`endif

    // Step-to-adv latency from a clean reset.
    reset = 1'b1; run = 1'b0; step = 1'b0;
    cyc(); cyc();
    chk("lat_reset", 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    step = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (adv === 1'b1) begin
        n = i;
        break;
      end
    end
    nvec++;
    if (n != 1 + LAT) begin
      nerr++;
      $display("FAIL step_latency: got adv after %0d cycles (0 = none within 8), want %0d",
               n, 1 + LAT);
    end
    chk("lat_addr", 1, 1, 0, 0);
    step = 1'b0;
    cyc();
    chk("lat_single_pulse", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
